gf180mcu_or_reduce_pipe: RTL and testbench

GF180MCU_OR_REDUCE_PIPE -- requirements
Module: gf180mcu_or_reduce_pipe

---
 rtl/gf180mcu_or_reduce_pkg.sv | 49 ++++
 rtl/gf180mcu_or_node.sv | 20 ++
 rtl/gf180mcu_or_reduce_pipe.sv | 87 ++++++++
 tb/tb_gf180mcu_or_reduce_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_or_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined OR-reduce tree.
package gf180mcu_or_reduce_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned FANIN_MIN = 2;
  localparam int unsigned FANIN_MAX = 4;
  localparam int unsigned LOOP_MAX  = 8;

  // Smallest S >= 1 with fanin**S >= width.
  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned fanin);
    int unsigned s;
    int unsigned p;
    s = 1;
    p = fanin;
    for (int i = 0; i < LOOP_MAX; i++) begin
      if (p < width) begin
        p = p * fanin;
        s = s + 1;
      end
    end
    return s;
  endfunction

  // Node count at a stage; stage 0 is the raw input vector.
  function automatic int unsigned stage_nodes(input int unsigned width, input int unsigned fanin,
                                              input int unsigned stage);
    int unsigned n;
    n = width;
    if (fanin >= FANIN_MIN) begin
      for (int unsigned i = 0; i < LOOP_MAX; i++) begin
        if (i < stage) n = (n + fanin - 1) / fanin;
      end
    end
    return n;
  endfunction

  // Bit offset of a stage's outputs within the flattened node register vector.
  function automatic int unsigned stage_offset(input int unsigned width, input int unsigned fanin,
                                               input int unsigned stage);
    int unsigned off;
    off = 0;
    for (int unsigned i = 1; i <= LOOP_MAX; i++) begin
      if (i < stage) off = off + stage_nodes(width, fanin, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/gf180mcu_or_node.sv
// One registered FANIN-input OR node of the reduction tree.
module gf180mcu_or_node #(
  parameter int unsigned FANIN = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [FANIN-1:0] d,
  output logic             q
);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      q <= 1'b0;
    end else if (EN) begin
      q <= |d;
    end
  end

endmodule

// File: rtl/gf180mcu_or_reduce_pipe.sv
// Pipelined OR-reduction of (A & MASK) with aligned valid chain and sticky result flag.
module gf180mcu_or_reduce_pipe
  import gf180mcu_or_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned FANIN = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             VLD_I,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] MASK,
  output logic             Z,
  output logic             VLD_O,
  output logic             ZS
);

  localparam int unsigned STAGES = calc_stages(WIDTH, FANIN);
  localparam int unsigned TOTAL  = stage_offset(WIDTH, FANIN, STAGES + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gf180mcu_or_reduce_pipe: WIDTH out of range 2..64");
  end
  if (FANIN < FANIN_MIN || FANIN > FANIN_MAX) begin : g_bad_fanin
    $error("gf180mcu_or_reduce_pipe: FANIN out of range 2..4");
  end

  logic [WIDTH-1:0]  masked_c;
  logic [TOTAL-1:0]  node_q;
  logic              z_next_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_next_c;
  logic              zs_q;

  assign masked_c = A & MASK;

  // Tree: stage s node j ORs group j of stage s-1; missing group bits tie to 0.
  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    localparam int unsigned N_IN    = stage_nodes(WIDTH, FANIN, s - 1);
    localparam int unsigned N_OUT   = stage_nodes(WIDTH, FANIN, s);
    localparam int unsigned OFF_IN  = stage_offset(WIDTH, FANIN, s - 1);
    localparam int unsigned OFF_OUT = stage_offset(WIDTH, FANIN, s);
    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      logic [FANIN-1:0] din;
      for (genvar k = 0; k < FANIN; k++) begin : g_in
        if (j * FANIN + k >= N_IN) begin : g_pad
          assign din[k] = 1'b0;
        end else if (s == 1) begin : g_src
          assign din[k] = masked_c[j*FANIN+k];
        end else begin : g_prev
          assign din[k] = node_q[OFF_IN+j*FANIN+k];
        end
      end
      gf180mcu_or_node #(.FANIN(FANIN)) u_node (
        .CLK (CLK),
        .RN  (RN),
        .EN  (EN),
        .d   (din),
        .q   (node_q[OFF_OUT+j])
      );
      // The sticky flag needs the value Z is about to take.
      if (s == STAGES) begin : g_last
        assign z_next_c = |din;
      end
    end
  end

  assign vld_next_c = STAGES'({vld_q, VLD_I});

  // Valid chain and sticky flag; a newly exiting valid 1 overrides CLR.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      vld_q <= '0;
      zs_q  <= 1'b0;
    end else if (EN) begin
      vld_q <= vld_next_c;
      zs_q  <= (zs_q & ~CLR) | (vld_next_c[STAGES-1] & z_next_c);
    end
  end

  assign Z     = node_q[TOTAL-1];
  assign VLD_O = vld_q[STAGES-1];
  assign ZS    = zs_q;

endmodule

// File: tb/tb_gf180mcu_or_reduce_pipe.sv
// Directed and randomized checks of the pipelined OR-reduce at three parameter points.
module tb_gf180mcu_or_reduce_pipe;

  logic clk = 1'b0;
  logic rn, en, clr;

  logic        vld_a, z_a, vo_a, zs_a;
  logic [8:0]  a_a, mask_a;
  logic        vld_b, z_b, vo_b, zs_b;
  logic [63:0] a_b, mask_b;
  logic        vld_c, z_c, vo_c, zs_c;
  logic [1:0]  a_c, mask_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf180mcu_or_reduce_pipe #(.WIDTH(9), .FANIN(3)) u_dut_a (
    .CLK(clk), .RN(rn), .EN(en), .CLR(clr), .VLD_I(vld_a), .A(a_a), .MASK(mask_a),
    .Z(z_a), .VLD_O(vo_a), .ZS(zs_a)
  );

  gf180mcu_or_reduce_pipe #(.WIDTH(64), .FANIN(4)) u_dut_b (
    .CLK(clk), .RN(rn), .EN(en), .CLR(clr), .VLD_I(vld_b), .A(a_b), .MASK(mask_b),
    .Z(z_b), .VLD_O(vo_b), .ZS(zs_b)
  );

  gf180mcu_or_reduce_pipe #(.WIDTH(2), .FANIN(4)) u_dut_c (
    .CLK(clk), .RN(rn), .EN(en), .CLR(clr), .VLD_I(vld_c), .A(a_c), .MASK(mask_c),
    .Z(z_c), .VLD_O(vo_c), .ZS(zs_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    vld_a  = 1'b0;
    a_a    = 9'h000;
    mask_a = 9'h1FF;
  endtask

  task automatic test_reset();
    rn = 1'b1; en = 1'b1; clr = 1'b0;
    idle_a();
    vld_b = 1'b0; a_b = '0; mask_b = '0;
    vld_c = 1'b0; a_c = '0; mask_c = '0;
    #2 rn = 1'b0;
    #5;
    checks++;
    if ({z_a, vo_a, zs_a, z_b, vo_b, zs_b, z_c, vo_c, zs_c} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {z_a, vo_a, zs_a, z_b, vo_b, zs_b, z_c, vo_c, zs_c}, 9'b0);
    end
    #5 rn = 1'b1;
    step();
  endtask

  task automatic test_mask();
    a_a = 9'h100; mask_a = 9'h0FF; vld_a = 1'b1;
    step();
    idle_a();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL mask_early got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b010) begin
      errors++; $display("FAIL mask_exit got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b010);
    end
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL mask_after got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
  endtask

  task automatic test_basic();
    a_a = 9'h100; mask_a = 9'h1FF; vld_a = 1'b1;
    step();
    idle_a();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL basic_early got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b111) begin
      errors++; $display("FAIL basic_exit got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b111);
    end
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b001) begin
      errors++; $display("FAIL basic_after got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b001);
    end
  endtask

  task automatic test_clr_set();
    a_a = 9'h001; vld_a = 1'b1;
    step();
    idle_a();
    clr = 1'b1;
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b111) begin
      errors++; $display("FAIL clr_vs_set got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b111);
    end
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL clr_alone got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
    clr = 1'b0;
  endtask

  task automatic test_stall();
    a_a = 9'h004; vld_a = 1'b1;
    step();
    idle_a();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({z_a, vo_a, zs_a} !== 3'b000) begin
        errors++; $display("FAIL stall_hold%0d got=%b exp=%b", i, {z_a, vo_a, zs_a}, 3'b000);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b111) begin
      errors++; $display("FAIL stall_exit got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b111);
    end
    en = 1'b0; clr = 1'b1;
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b111) begin
      errors++; $display("FAIL stall_clr_ignored got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b111);
    end
    en = 1'b1;
    step();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL stall_clr_applied got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_a = 9'h002; vld_a = 1'b1;
    step();
    a_a = 9'h040; vld_a = 1'b1;
    step();
    idle_a();
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b111) begin
      errors++; $display("FAIL rstmid_before got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b111);
    end
    rn = 1'b0;
    #1;
    checks++;
    if ({z_a, vo_a, zs_a} !== 3'b000) begin
      errors++; $display("FAIL rstmid_async got=%b exp=%b", {z_a, vo_a, zs_a}, 3'b000);
    end
    #3 rn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({z_a, vo_a, zs_a} !== 3'b000) begin
        errors++; $display("FAIL rstmid_after%0d got=%b exp=%b", i, {z_a, vo_a, zs_a}, 3'b000);
      end
    end
  endtask

  task automatic test_single_stage();
    a_c = 2'b10; mask_c = 2'b11; vld_c = 1'b1;
    step();
    checks++;
    if ({z_c, vo_c, zs_c} !== 3'b111) begin
      errors++; $display("FAIL single_hit got=%b exp=%b", {z_c, vo_c, zs_c}, 3'b111);
    end
    mask_c = 2'b01;
    step();
    checks++;
    if ({z_c, vo_c, zs_c} !== 3'b011) begin
      errors++; $display("FAIL single_masked got=%b exp=%b", {z_c, vo_c, zs_c}, 3'b011);
    end
    vld_c = 1'b0;
    step();
    checks++;
    if ({z_c, vo_c, zs_c} !== 3'b001) begin
      errors++; $display("FAIL single_idle got=%b exp=%b", {z_c, vo_c, zs_c}, 3'b001);
    end
  endtask

  task automatic test_random();
    logic hist_v [3];
    logic hist_z [3];
    logic ref_z;
    for (int i = 0; i < 3; i++) begin
      hist_v[i] = 1'b0;
      hist_z[i] = 1'b0;
    end
    for (int n = 0; n < 10000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       a_b = '0;
        1:       a_b = 64'd1 << $urandom_range(0, 63);
        default: a_b = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       mask_b = '0;
        1:       mask_b = 64'd1 << $urandom_range(0, 63);
        2:       mask_b = '1;
        default: mask_b = {$urandom, $urandom};
      endcase
      vld_b = 1'($urandom_range(0, 1));
      ref_z = |(a_b & mask_b);
      step();
      if (en) begin
        hist_v[2] = hist_v[1]; hist_z[2] = hist_z[1];
        hist_v[1] = hist_v[0]; hist_z[1] = hist_z[0];
        hist_v[0] = vld_b;     hist_z[0] = ref_z;
      end
      checks++;
      if (vo_b !== hist_v[2]) begin
        errors++; $display("FAIL rand_vld cyc=%0d got=%b exp=%b", n, vo_b, hist_v[2]);
      end
      if (hist_v[2]) begin
        checks++;
        if (z_b !== hist_z[2]) begin
          errors++; $display("FAIL rand_z cyc=%0d got=%b exp=%b", n, z_b, hist_z[2]);
        end
      end
    end
    en = 1'b1;
    vld_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mask();
    test_basic();
    test_clr_set();
    test_stall();
    test_reset_mid();
    test_single_stage();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
